// File: rtl/issue_ctrl.sv
// Fetch/issue sequencer: fetches by PC, holds each instruction, and issues it to decode only
// once the per-register pending-write scoreboard shows no hazard; drains writes on HALT.
module issue_ctrl #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] START_PC = {PC_W{1'b0}},
    parameter logic [15:0]     NOP_INST = 16'h0000,
    parameter logic [3:0]      HALT_OP  = 4'hF,
    parameter int              CNT_W    = 2
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iSTART,
    output logic            oFETCH_REQ,
    output logic [PC_W-1:0] oPC,
    input  logic            iINST_VALID,
    input  logic [15:0]     iINST,
    output logic [15:0]     oHOLD_INST,
    input  logic [3:0]      iEXE_OP,
    input  logic [1:0]      iIN1_IDX,
    input  logic [1:0]      iIN2_IDX,
    input  logic            iSRC2_IS_REG,
    input  logic [1:0]      iDST_IDX,
    input  logic            iHAS_DST,
    input  logic            iWB_VALID,
    input  logic [1:0]      iWB_IDX,
    output logic [15:0]     oINST,
    output logic            oISSUE,
    output logic            oSTALL,
    output logic            oBUSY,
    output logic            oDONE,
    output logic            oERR
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [PC_W-1:0]  PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};

    logic [1:0]                 state_q, state_d;
    logic [PC_W-1:0]            pc_q, pc_d;
    logic [3:0][CNT_W-1:0]      pend_q, pend_d;
    logic [15:0]                hold_q, hold_d;
    logic [15:0]                inst_q, inst_d;
    logic                       fetch_req_q, fetch_req_d;
    logic                       issue_q, issue_d;
    logic                       stall_q, stall_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       hazard_s;
    logic                       inc_en_s;
    logic                       all_clear_s;

    // Hazard uses the registered scoreboard only; a write retiring this cycle is seen next cycle.
    always_comb begin
        hazard_s = (pend_q[iIN1_IDX] != CNT_ZERO)
                 | (iSRC2_IS_REG & (pend_q[iIN2_IDX] != CNT_ZERO))
                 | (iHAS_DST & (pend_q[iDST_IDX] == CNT_MAX));
        all_clear_s = (pend_q == {(4*CNT_W){1'b0}});
    end

    // Sequencer next-state and registered output values.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        hold_d   = hold_q;
        inst_d   = NOP_INST;
        issue_d  = 1'b0;
        stall_d  = 1'b0;
        done_d   = 1'b0;
        inc_en_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iSTART) begin
                    pc_d    = START_PC;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (iINST_VALID) begin
                    hold_d  = iINST;
                    state_d = S_CHECK;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_CHECK: begin
                if (hazard_s) begin
                    stall_d = 1'b1;
                    state_d = S_CHECK;
                end else begin
                    inst_d   = hold_q;
                    issue_d  = 1'b1;
                    inc_en_s = iHAS_DST;
                    pc_d     = pc_q + PC_ONE;
                    state_d  = (iEXE_OP == HALT_OP) ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                if (all_clear_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HALT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        fetch_req_d = (state_d == S_FETCH);
        busy_d      = (state_d != S_IDLE);
    end

    // Scoreboard update: issue increments, retire decrements, both together cancel out.
    always_comb begin
        pend_d = pend_q;
        err_d  = err_q;
        for (int i = 0; i < 4; i++) begin
            if (iWB_VALID && (iWB_IDX == 2'(i))) begin
                if (pend_q[i] == CNT_ZERO) begin
                    err_d = 1'b1;
                    if (inc_en_s && (iDST_IDX == 2'(i))) begin
                        pend_d[i] = pend_q[i] + CNT_ONE;
                    end else begin
                        pend_d[i] = pend_q[i];
                    end
                end else if (inc_en_s && (iDST_IDX == 2'(i))) begin
                    pend_d[i] = pend_q[i];
                end else begin
                    pend_d[i] = pend_q[i] - CNT_ONE;
                end
            end else if (inc_en_s && (iDST_IDX == 2'(i))) begin
                pend_d[i] = pend_q[i] + CNT_ONE;
            end else begin
                pend_d[i] = pend_q[i];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= S_IDLE;
            pc_q        <= {PC_W{1'b0}};
            pend_q      <= {(4*CNT_W){1'b0}};
            hold_q      <= NOP_INST;
            inst_q      <= NOP_INST;
            fetch_req_q <= 1'b0;
            issue_q     <= 1'b0;
            stall_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            hold_q      <= hold_d;
            inst_q      <= inst_d;
            fetch_req_q <= fetch_req_d;
            issue_q     <= issue_d;
            stall_q     <= stall_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign oFETCH_REQ = fetch_req_q;
    assign oPC        = pc_q;
    assign oHOLD_INST = hold_q;
    assign oINST      = inst_q;
    assign oISSUE     = issue_q;
    assign oSTALL     = stall_q;
    assign oBUSY      = busy_q;
    assign oDONE      = done_q;
    assign oERR       = err_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Scoreboard bench for issue_ctrl: served instructions are queued as expected issues and a
// monitor compares every issued word; directed checks cover stalls, HALT drain, wrap and reset.
module tb_issue_ctrl;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iSTART = 1'b0;
    logic        oFETCH_REQ;
    logic [7:0]  oPC;
    logic        iINST_VALID = 1'b0;
    logic [15:0] iINST = 16'h0000;
    logic [15:0] oHOLD_INST;
    logic [3:0]  iEXE_OP;
    logic [1:0]  iIN1_IDX;
    logic [1:0]  iIN2_IDX;
    logic        iSRC2_IS_REG;
    logic [1:0]  iDST_IDX;
    logic        iHAS_DST;
    logic        iWB_VALID = 1'b0;
    logic [1:0]  iWB_IDX = 2'd0;
    logic [15:0] oINST;
    logic        oISSUE;
    logic        oSTALL;
    logic        oBUSY;
    logic        oDONE;
    logic        oERR;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    always #5 iCLK = ~iCLK;

    // Bench decode: [15:12] op, [11:10] dst, [9:8] src1, [7:6] src2, [5] src2 is reg, [4] has dst
    assign iEXE_OP      = oHOLD_INST[15:12];
    assign iDST_IDX     = oHOLD_INST[11:10];
    assign iIN1_IDX     = oHOLD_INST[9:8];
    assign iIN2_IDX     = oHOLD_INST[7:6];
    assign iSRC2_IS_REG = oHOLD_INST[5];
    assign iHAS_DST     = oHOLD_INST[4];

    issue_ctrl dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART),
        .oFETCH_REQ(oFETCH_REQ), .oPC(oPC),
        .iINST_VALID(iINST_VALID), .iINST(iINST), .oHOLD_INST(oHOLD_INST),
        .iEXE_OP(iEXE_OP), .iIN1_IDX(iIN1_IDX), .iIN2_IDX(iIN2_IDX),
        .iSRC2_IS_REG(iSRC2_IS_REG), .iDST_IDX(iDST_IDX), .iHAS_DST(iHAS_DST),
        .iWB_VALID(iWB_VALID), .iWB_IDX(iWB_IDX),
        .oINST(oINST), .oISSUE(oISSUE), .oSTALL(oSTALL),
        .oBUSY(oBUSY), .oDONE(oDONE), .oERR(oERR)
    );

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] dst,
                                       input logic [1:0] s1, input logic [1:0] s2,
                                       input logic s2reg, input logic hasdst,
                                       input logic [3:0] tag);
        return {op, dst, s1, s2, s2reg, hasdst, tag};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait (bounded) for a fetch request, optionally delay, then return the word for one cycle.
    task automatic serve(input logic [15:0] inst, input int delay, input bit push);
        int n = 0;
        while (!oFETCH_REQ && n < 50) begin
            @(negedge iCLK);
            n++;
        end
        if (!oFETCH_REQ) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: no fetch request within 50 cycles at %0t", $time);
        end else begin
            repeat (delay) @(negedge iCLK);
            iINST_VALID = 1'b1;
            iINST       = inst;
            if (push) exp_q.push_back(inst);
            @(negedge iCLK);
            iINST_VALID = 1'b0;
        end
    endtask

    task automatic expect_issue(input string name);
        @(negedge iCLK);
        chk(name, {31'd0, oISSUE}, 32'd1);
    endtask

    task automatic wb(input logic [1:0] idx, input int cycles);
        iWB_VALID = 1'b1;
        iWB_IDX   = idx;
        repeat (cycles) @(negedge iCLK);
        iWB_VALID = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_fetch_req"}, {31'd0, oFETCH_REQ}, 32'd0);
        chk({tag, "_pc"},        {24'd0, oPC}, 32'd0);
        chk({tag, "_hold"},      {16'd0, oHOLD_INST}, 32'd0);
        chk({tag, "_inst"},      {16'd0, oINST}, 32'd0);
        chk({tag, "_issue"},     {31'd0, oISSUE}, 32'd0);
        chk({tag, "_stall"},     {31'd0, oSTALL}, 32'd0);
        chk({tag, "_busy"},      {31'd0, oBUSY}, 32'd0);
        chk({tag, "_done"},      {31'd0, oDONE}, 32'd0);
        chk({tag, "_err"},       {31'd0, oERR}, 32'd0);
    endtask

    // Monitor: every issue must match the oldest queued instruction; otherwise oINST is NOP.
    initial begin
        logic [15:0] exp_w;
        forever begin
            @(negedge iCLK);
            checks++;
            if (oISSUE) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected: got %h with empty queue at %0t", oINST, $time);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (oINST !== exp_w) begin
                        errors++;
                        $display("FAIL issue_word: got %h expected %h at %0t", oINST, exp_w, $time);
                    end
                end
            end else if (oINST !== 16'h0000) begin
                errors++;
                $display("FAIL idle_nop: got %h expected 0000 at %0t", oINST, $time);
            end
        end
    end

    initial begin
        logic [15:0] w;
        logic [3:0]  tag;

        repeat (2) @(negedge iCLK);
        chk_reset_outputs("rst");
        iRST = 1'b0;
        @(negedge iCLK);

        // r1 <- imm, memory answers one cycle after the request
        iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
        chk("start_fetch_req", {31'd0, oFETCH_REQ}, 32'd1);
        chk("start_pc", {24'd0, oPC}, 32'd0);
        chk("start_busy", {31'd0, oBUSY}, 32'd1);
        serve(mk(4'h1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 4'h1), 1, 1'b1);
        chk("hold_a", {16'd0, oHOLD_INST}, {16'd0, mk(4'h1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 4'h1)});
        chk("a_no_issue_yet", {31'd0, oISSUE}, 32'd0);
        expect_issue("issue_a");

        // r1 <- r1: stalls until WB r1, then one extra stall cycle
        serve(mk(4'h3, 2'd1, 2'd1, 2'd0, 1'b0, 1'b1, 4'h2), 0, 1'b1);
        repeat (3) @(negedge iCLK);
        chk("raw_stall", {31'd0, oSTALL}, 32'd1);
        chk("raw_no_issue", {31'd0, oISSUE}, 32'd0);
        wb(2'd1, 1);
        chk("raw_wb_cycle_stall", {31'd0, oSTALL}, 32'd1);
        chk("raw_wb_cycle_issue", {31'd0, oISSUE}, 32'd0);
        expect_issue("issue_b");
        chk("raw_stall_cleared", {31'd0, oSTALL}, 32'd0);

        // immediate src2 naming pending r1 must not stall
        serve(mk(4'h4, 2'd3, 2'd0, 2'd1, 1'b0, 1'b0, 4'h3), 0, 1'b1);
        expect_issue("issue_imm_src2");
        chk("imm_no_stall", {31'd0, oSTALL}, 32'd0);
        wb(2'd1, 1);

        // three writes to r2 fill its counter; the fourth waits for one retire
        for (int i = 0; i < 3; i++) begin
            tag = 4'(i + 4);
            serve(mk(4'h5, 2'd2, 2'd0, 2'd0, 1'b0, 1'b1, tag), 0, 1'b1);
            expect_issue("issue_r2_write");
        end
        serve(mk(4'h5, 2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 4'h7), 0, 1'b1);
        repeat (3) @(negedge iCLK);
        chk("waw_full_stall", {31'd0, oSTALL}, 32'd1);
        wb(2'd2, 1);
        chk("waw_wb_cycle_issue", {31'd0, oISSUE}, 32'd0);
        expect_issue("issue_r2_fourth");
        wb(2'd2, 2);

        // HALT with one outstanding write to r2
        serve(mk(4'hF, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'h8), 0, 1'b1);
        expect_issue("issue_halt");
        repeat (3) begin
            @(negedge iCLK);
            chk("halt_wait_done", {31'd0, oDONE}, 32'd0);
            chk("halt_wait_busy", {31'd0, oBUSY}, 32'd1);
        end
        wb(2'd2, 1);
        chk("halt_wb_cycle_done", {31'd0, oDONE}, 32'd0);
        @(negedge iCLK);
        chk("halt_done", {31'd0, oDONE}, 32'd1);
        chk("halt_idle_busy", {31'd0, oBUSY}, 32'd0);
        @(negedge iCLK);
        chk("done_pulse", {31'd0, oDONE}, 32'd0);
        chk("no_err_yet", {31'd0, oERR}, 32'd0);

        // second run: walk PC up to 255 and across the wrap
        iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
        chk("restart_pc", {24'd0, oPC}, 32'd0);
        for (int i = 0; i < 255; i++) begin
            tag = 4'(i);
            serve(mk(4'h2, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, tag), 0, 1'b1);
            expect_issue("issue_walk");
        end
        chk("pc_255", {24'd0, oPC}, 32'd255);
        serve(mk(4'h6, 2'd3, 2'd0, 2'd0, 1'b0, 1'b1, 4'h9), 0, 1'b1);
        expect_issue("issue_at_255");
        chk("pc_wrap", {24'd0, oPC}, 32'd0);

        // reader of r3 stalls in CHECK; asynchronous reset takes effect within the cycle
        w = mk(4'h7, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 4'hA);
        serve(w, 0, 1'b0);
        repeat (2) @(negedge iCLK);
        chk("pre_reset_stall", {31'd0, oSTALL}, 32'd1);
        iRST = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        chk("queue_drained", exp_q.size(), 32'd0);
        @(negedge iCLK);
        iRST = 1'b0;
        exp_q.delete();
        @(negedge iCLK);
        chk("post_reset_busy", {31'd0, oBUSY}, 32'd0);

        // retire with nothing pending sets the sticky error, even in IDLE
        wb(2'd3, 1);
        chk("err_set", {31'd0, oERR}, 32'd1);
        repeat (2) @(negedge iCLK);
        chk("err_sticky", {31'd0, oERR}, 32'd1);
        chk("end_queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
